csr_trap_unit: RTL and testbench

- Machine-mode CSR file and trap sequencer for the RV32I core.
- Consumes the early-decode outputs of the fetch stage: CSR address/funct3, mret/ecall/ebreak/illegal flags and the instruction PC.
- Produces the fetch stage's redirect controls: Take_trap, Trap_Return, EPC_OUT and MTVEC.
- Also executes Zicsr read/modify/write, holds the cycle/instret counters and gates one external interrupt.

---
 rtl/csr_pkg.sv | 35 +++
 rtl/csr_trap_unit_counter64.sv | 36 +++
 rtl/csr_trap_unit.sv | 193 +++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file and trap sequencer:
// CSR addresses, cause codes, Zicsr op encodings and sequencer states.
package csr_pkg;

    localparam logic [11:0] CsrMstatus  = 12'h300;
    localparam logic [11:0] CsrMie      = 12'h304;
    localparam logic [11:0] CsrMtvec    = 12'h305;
    localparam logic [11:0] CsrMscratch = 12'h340;
    localparam logic [11:0] CsrMepc     = 12'h341;
    localparam logic [11:0] CsrMcause   = 12'h342;
    localparam logic [11:0] CsrMtval    = 12'h343;
    localparam logic [11:0] CsrMip      = 12'h344;
    localparam logic [11:0] CsrMcycle   = 12'hB00;
    localparam logic [11:0] CsrMinstret = 12'hB02;
    localparam logic [11:0] CsrMcycleh  = 12'hB80;
    localparam logic [11:0] CsrMinstreth = 12'hB82;
    localparam logic [11:0] CsrMhartid  = 12'hF14;

    localparam logic [31:0] CauseIllegal = 32'd2;
    localparam logic [31:0] CauseBreak   = 32'd3;
    localparam logic [31:0] CauseEcall   = 32'd11;
    localparam logic [31:0] CauseExtIrq  = 32'h8000_000B;

    // funct3[1:0]; funct3[2] selects the zero-extended immediate source
    localparam logic [1:0] OpRw = 2'b01;
    localparam logic [1:0] OpRs = 2'b10;
    localparam logic [1:0] OpRc = 2'b11;

    typedef enum logic [1:0] {
        StRun,
        StTrap,
        StMret
    } state_e;

endpackage

// File: rtl/csr_trap_unit_counter64.sv
// 64-bit wrapping counter with an increment enable and a 32-bit half-select
// write port; a write to either half overrides that cycle's increment.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (wr_lo_i) begin
            count_d = {count_q[63:32], wdata_i};
        end else if (wr_hi_i) begin
            count_d = {wdata_i, count_q[31:0]};
        end else if (inc_i) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer: Zicsr read/modify/write, trap and
// mret redirect pulses, cycle/instret counters and one gated external interrupt.
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0] HART_ID     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] pc,
    input  logic        is_mret,
    input  logic        is_ecall_ebreak,
    input  logic        is_illegal_instr,
    input  logic        is_ebreak,
    input  logic [11:0] CSR_ADDR,
    input  logic [2:0]  CSR_funct3,
    input  logic [31:0] csr_src,
    input  logic [4:0]  csr_zimm,
    input  logic        ext_irq,
    output logic [31:0] csr_rdata,
    output logic        Take_trap,
    output logic        Trap_Return,
    output logic [31:0] EPC_OUT,
    output logic [31:0] MTVEC,
    output logic        busy
);

    state_e      state_d, state_q;
    logic        mie_d, mie_q, mpie_d, mpie_q, meie_d, meie_q;
    logic [31:0] mtvec_d, mtvec_q, mscratch_d, mscratch_q, mepc_d, mepc_q;
    logic [31:0] mcause_d, mcause_q, mtval_d, mtval_q;
    logic [63:0] mcycle, minstret;

    logic        csr_op, wr_req, addr_ok, read_only, csr_illegal;
    logic        run_valid, sync_trap, irq_trap, trap, do_wr;
    logic [31:0] src, wdata;

    always_comb begin
        csr_op    = CSR_funct3[1:0] != 2'b00;
        src       = CSR_funct3[2] ? {27'b0, csr_zimm} : csr_src;
        wr_req    = csr_op && (CSR_funct3[1:0] == OpRw || src != 32'b0);
        addr_ok   = 1'b1;
        read_only = 1'b0;
        csr_rdata = 32'b0;
        case (CSR_ADDR)
            CsrMstatus:   csr_rdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            CsrMie:       csr_rdata = {20'b0, meie_q, 11'b0};
            CsrMtvec:     csr_rdata = mtvec_q;
            CsrMscratch:  csr_rdata = mscratch_q;
            CsrMepc:      csr_rdata = mepc_q;
            CsrMcause:    csr_rdata = mcause_q;
            CsrMtval:     csr_rdata = mtval_q;
            CsrMcycle:    csr_rdata = mcycle[31:0];
            CsrMcycleh:   csr_rdata = mcycle[63:32];
            CsrMinstret:  csr_rdata = minstret[31:0];
            CsrMinstreth: csr_rdata = minstret[63:32];
            CsrMip: begin
                csr_rdata = {20'b0, ext_irq, 11'b0};
                read_only = 1'b1;
            end
            CsrMhartid: begin
                csr_rdata = HART_ID;
                read_only = 1'b1;
            end
            default: addr_ok = 1'b0;
        endcase
        csr_illegal = csr_op && (!addr_ok || (read_only && wr_req));

        case (CSR_funct3[1:0])
            OpRs:    wdata = csr_rdata | src;
            OpRc:    wdata = csr_rdata & ~src;
            default: wdata = src;
        endcase

        run_valid = valid && state_q == StRun;
        sync_trap = run_valid && (is_illegal_instr || csr_illegal || is_ecall_ebreak);
        irq_trap  = run_valid && !sync_trap && ext_irq && mie_q && meie_q;
        trap      = sync_trap || irq_trap;
        // A same-cycle mtvec write survives the trap so the redirect already uses it.
        do_wr     = run_valid && wr_req && !csr_illegal && (!trap || CSR_ADDR == CsrMtvec);
    end

    always_comb begin
        state_d    = state_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        meie_d     = meie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;

        if (do_wr) begin
            case (CSR_ADDR)
                CsrMstatus: begin
                    mie_d  = wdata[3];
                    mpie_d = wdata[7];
                end
                CsrMie:      meie_d     = wdata[11];
                CsrMtvec:    mtvec_d    = {wdata[31:2], 2'b00};
                CsrMscratch: mscratch_d = wdata;
                CsrMepc:     mepc_d     = {wdata[31:2], 2'b00};
                CsrMcause:   mcause_d   = wdata;
                CsrMtval:    mtval_d    = wdata;
                default: ;
            endcase
        end

        unique case (state_q)
            StRun: begin
                if (trap) begin
                    state_d = StTrap;
                    mepc_d  = {pc[31:2], 2'b00};
                    mpie_d  = mie_q;
                    mie_d   = 1'b0;
                    if (is_illegal_instr || csr_illegal) begin
                        mcause_d = CauseIllegal;
                        mtval_d  = pc;
                    end else if (is_ecall_ebreak) begin
                        mcause_d = is_ebreak ? CauseBreak : CauseEcall;
                        mtval_d  = 32'b0;
                    end else begin
                        mcause_d = CauseExtIrq;
                        mtval_d  = 32'b0;
                    end
                end else if (run_valid && is_mret) begin
                    state_d = StMret;
                end
            end
            StTrap: state_d = StRun;
            StMret: begin
                state_d = StRun;
                mie_d   = mpie_q;
                mpie_d  = 1'b1;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StRun;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            meie_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            state_q    <= state_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            meie_q     <= meie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk_i   (clk),
        .rst_ni  (rst),
        .inc_i   (1'b1),
        .wr_lo_i (do_wr && CSR_ADDR == CsrMcycle),
        .wr_hi_i (do_wr && CSR_ADDR == CsrMcycleh),
        .wdata_i (wdata),
        .count_o (mcycle)
    );

    csr_counter64 u_minstret (
        .clk_i   (clk),
        .rst_ni  (rst),
        .inc_i   (run_valid && !trap),
        .wr_lo_i (do_wr && CSR_ADDR == CsrMinstret),
        .wr_hi_i (do_wr && CSR_ADDR == CsrMinstreth),
        .wdata_i (wdata),
        .count_o (minstret)
    );

    assign Take_trap   = state_q == StTrap;
    assign Trap_Return = state_q == StMret;
    assign busy        = state_q != StRun;
    assign EPC_OUT     = mepc_q;
    assign MTVEC       = mtvec_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: expected values are queued when a step is
// driven and popped/compared on the following falling edge.
module tb_csr_trap_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] pc;
    logic        is_mret, is_ecall_ebreak, is_illegal_instr, is_ebreak;
    logic [11:0] CSR_ADDR;
    logic [2:0]  CSR_funct3;
    logic [31:0] csr_src;
    logic [4:0]  csr_zimm;
    logic        ext_irq;
    logic [31:0] csr_rdata;
    logic        Take_trap, Trap_Return;
    logic [31:0] EPC_OUT, MTVEC;
    logic        busy;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    csr_trap_unit #(
        .MTVEC_RESET (32'h0000_0100),
        .HART_ID     (32'h0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .valid            (valid),
        .pc               (pc),
        .is_mret          (is_mret),
        .is_ecall_ebreak  (is_ecall_ebreak),
        .is_illegal_instr (is_illegal_instr),
        .is_ebreak        (is_ebreak),
        .CSR_ADDR         (CSR_ADDR),
        .CSR_funct3       (CSR_funct3),
        .csr_src          (csr_src),
        .csr_zimm         (csr_zimm),
        .ext_irq          (ext_irq),
        .csr_rdata        (csr_rdata),
        .Take_trap        (Take_trap),
        .Trap_Return      (Trap_Return),
        .EPC_OUT          (EPC_OUT),
        .MTVEC            (MTVEC),
        .busy             (busy)
    );

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h, required an expected entry", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
        end
    endtask

    task automatic idle();
        valid = 0; pc = 0; is_mret = 0; is_ecall_ebreak = 0; is_illegal_instr = 0;
        is_ebreak = 0; CSR_ADDR = 0; CSR_funct3 = 0; csr_src = 0; csr_zimm = 0;
    endtask

    task automatic csr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] s,
                       input logic [4:0] z, input logic [31:0] p);
        idle();
        valid = 1; CSR_funct3 = f3; CSR_ADDR = a; csr_src = s; csr_zimm = z; pc = p;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Read a CSR with CSRRS and a zero source (no write) and check the old value.
    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] v);
        csr(3'b010, a, 32'h0, 5'h0, 32'h0);
        push(tag, v);
        samp();
        chk(csr_rdata);
        nxt();
    endtask

    initial begin
        idle();
        ext_irq = 0;
        rst = 0;
        nxt();
        nxt();
        rst = 1;

        push("rst_busy", 32'h0);      push("rst_take", 32'h0);  push("rst_ret", 32'h0);
        push("rst_mtvec", 32'h100);   push("rst_epc", 32'h0);
        samp();
        chk({31'b0, busy}); chk({31'b0, Take_trap}); chk({31'b0, Trap_Return});
        chk(MTVEC); chk(EPC_OUT);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);

        csr(3'b001, 12'h340, 32'hDEAD_BEEF, 5'h0, 32'h10);
        push("rw_mscratch_old", 32'h0);
        samp(); chk(csr_rdata); nxt();
        rd("rs_zero_mscratch", 12'h340, 32'hDEAD_BEEF);
        rd("mhartid", 12'hF14, 32'h0);

        csr(3'b110, 12'h300, 32'h0, 5'd8, 32'h20);
        push("set_mie_old", 32'h0000_1800);
        samp(); chk(csr_rdata); nxt();

        // ecall at 0x40; the TRAP cycle carries a CSR write that must be ignored
        idle(); valid = 1; pc = 32'h40; is_ecall_ebreak = 1;
        push("ecall_busy_run", 32'h0);
        samp(); chk({31'b0, busy}); nxt();
        csr(3'b001, 12'h340, 32'h1234, 5'h0, 32'h44);
        push("ecall_take", 32'h1); push("ecall_busy", 32'h1);
        push("ecall_mtvec", 32'h100); push("ecall_epc", 32'h40);
        samp(); chk({31'b0, Take_trap}); chk({31'b0, busy}); chk(MTVEC); chk(EPC_OUT);
        nxt();
        idle();
        push("post_trap_busy", 32'h0); push("post_trap_take", 32'h0);
        samp(); chk({31'b0, busy}); chk({31'b0, Take_trap});
        rd("ecall_mcause", 12'h342, 32'd11);
        rd("ecall_mstatus", 12'h300, 32'h0000_1880);
        rd("trap_cycle_ignored", 12'h340, 32'hDEAD_BEEF);

        idle(); valid = 1; is_mret = 1; pc = 32'h48;
        nxt();
        idle();
        push("mret_ret", 32'h1); push("mret_epc", 32'h40); push("mret_busy", 32'h1);
        samp(); chk({31'b0, Trap_Return}); chk(EPC_OUT); chk({31'b0, busy});
        nxt();
        push("mret_done", 32'h0);
        samp(); chk({31'b0, Trap_Return});
        rd("mret_mstatus", 12'h300, 32'h0000_1888);

        csr(3'b010, 12'h304, 32'h800, 5'h0, 32'h50);
        push("set_meie_old", 32'h0);
        samp(); chk(csr_rdata); nxt();
        idle(); valid = 1; pc = 32'h80; ext_irq = 1;
        nxt();
        idle(); ext_irq = 0;
        push("irq_take", 32'h1); push("irq_epc", 32'h80);
        samp(); chk({31'b0, Take_trap}); chk(EPC_OUT);
        nxt();
        rd("irq_mcause", 12'h342, 32'h8000_000B);

        csr(3'b110, 12'h300, 32'h0, 5'd8, 32'h0);
        push("reset_mie_old", 32'h0000_1880);
        samp(); chk(csr_rdata); nxt();
        csr(3'b001, 12'h7FF, 32'h5, 5'h0, 32'hC0); ext_irq = 1;
        nxt();
        idle(); ext_irq = 0;
        push("illegal_take", 32'h1);
        samp(); chk({31'b0, Take_trap}); nxt();
        rd("illegal_mcause", 12'h342, 32'd2);
        rd("illegal_mtval", 12'h343, 32'hC0);

        csr(3'b001, 12'hF14, 32'h7, 5'h0, 32'hC4);
        nxt();
        idle();
        push("hartid_wr_take", 32'h1);
        samp(); chk({31'b0, Take_trap}); nxt();
        rd("hartid_wr_mcause", 12'h342, 32'd2);
        rd("hartid_wr_mtval", 12'h343, 32'hC4);

        idle(); valid = 1; pc = 32'hC8; is_ecall_ebreak = 1; is_ebreak = 1;
        nxt();
        idle(); nxt();
        rd("ebreak_mcause", 12'h342, 32'd3);
        rd("ebreak_mtval", 12'h343, 32'h0);

        csr(3'b001, 12'h305, 32'h0000_0203, 5'h0, 32'hD0);
        nxt();
        idle();
        push("mtvec_low_bits", 32'h200);
        samp(); chk(MTVEC);

        csr(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'h0, 32'h0); nxt();
        csr(3'b001, 12'hB80, 32'hFFFF_FFFF, 5'h0, 32'h0); nxt();
        idle(); nxt();
        nxt();
        rd("mcycle_wrap_lo", 12'hB00, 32'h1);
        rd("mcycle_wrap_hi", 12'hB80, 32'h0);

        csr(3'b001, 12'hB02, 32'h0, 5'h0, 32'h0); nxt();
        idle(); valid = 1; pc = 32'hE0; nxt();
        rd("minstret_count", 12'hB02, 32'h1);

        idle(); valid = 1; pc = 32'h100; is_ecall_ebreak = 1;
        nxt();
        idle(); rst = 0;
        push("pre_rst_take", 32'h1);
        samp(); chk({31'b0, Take_trap}); nxt();
        rst = 1;
        push("rst_trap_take", 32'h0); push("rst_trap_busy", 32'h0);
        push("rst_trap_epc", 32'h0);  push("rst_trap_mtvec", 32'h100);
        samp(); chk({31'b0, Take_trap}); chk({31'b0, busy}); chk(EPC_OUT); chk(MTVEC);
        nxt();
        push("rst_trap_take_after", 32'h0);
        samp(); chk({31'b0, Take_trap});
        rd("rst_trap_mscratch", 12'h340, 32'h0);
        rd("rst_trap_mcause", 12'h342, 32'h0);
        rd("rst_trap_mstatus", 12'h300, 32'h0000_1800);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
